if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the five-stage pipelined CPU: holds the program counter, drives the instruction-memory address, and captures the fetched word into the IF/ID pipeline register. It sits directly upstream of the next-PC logic. It consumes that logic's redirect result (target address, jump flag, taken-branch flag), and produces the PC+4 value the next-PC logic uses for branch targets. It also implements pipeline stall, wrong-path flush, a halt/resume state machine, and optional performance counters.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_W, 32, width of each performance counter
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit hold; freezes PC and IF/ID
- jmp  in  1  unconditional redirect from next-PC logic (j/jal/jr)
- correct_b  in  1  taken conditional branch from next-PC logic
- npc_in  in  32  redirect target from next-PC logic
- halt_req  in  1  halt instruction decoded in ID
- go  in  1  resume request (debounced button pulse)
- imem_data  in  32  instruction word; combinational read of imem_addr
- imem_addr  out  32  current PC
- if_id_ir  out  32  registered instruction
- if_id_pc1  out  32  registered PC+4 of that instruction
- if_id_valid  out  1  IF/ID holds a real instruction
- halted  out  1  state machine is in HALT
- cnt_cycle, cnt_jmp, cnt_branch  out  CNT_W each  performance counters

## Operation
- States: RUN, HALT. Reset state RUN.
- Per-cycle action priority: rst > halt > stall > redirect > sequential.
- rst: PC=RESET_PC; if_id_ir=0, if_id_pc1=0, if_id_valid=0; state RUN; all counters 0; halted=0.
- RUN, halt_req=1: go to HALT; PC held; IF/ID loads bubble (ir=0, valid=0). Any stall/redirect in the same cycle is ignored.
- RUN, stall=1: PC and IF/ID hold. jmp/correct_b are ignored, because ID operands are stale; they are re-presented next cycle.
- RUN, redirect (jmp|correct_b): PC=npc_in; IF/ID loads bubble, flushing the wrong-path fetch. There is no delay slot.
- RUN, otherwise: PC=PC+4 (mod 2^32); if_id_ir=imem_data, if_id_pc1=PC+4, if_id_valid=1.
- HALT: PC and counters frozen; IF/ID holds bubble; inputs other than rst and go are ignored. go=1 returns to RUN next cycle, and fetch resumes at the held PC (the instruction after the halt). go in RUN has no effect.
- imem_addr equals PC at all times, including during reset.

## Timing
- Sequential fetch: the word at address A appears on if_id_ir one edge after PC=A.
- Redirect latency: redirect sampled at edge n sets PC=target. The target instruction is in IF/ID after edge n+1, giving exactly one bubble per redirect.
- Stall: holds for as many cycles as asserted. The first non-stalled cycle resumes with the held PC; a redirect presented then takes effect.
- halt_req at edge n: halted=1 after edge n. go at edge m (m>n): halted=0 after edge m, and the first valid fetch lands in IF/ID after edge m+1.
- Reset asserted mid-stall, mid-HALT or with a redirect pending: reset wins in that cycle, and all outputs take reset values after the edge.

## Configuration
- IF_STATS_EN defined: counters active, each wrapping modulo 2^CNT_W.
  - cnt_cycle increments every RUN cycle, including stalls.
  - cnt_jmp increments on each accepted jmp redirect.
  - cnt_branch increments on each accepted correct_b redirect when jmp=0.
  - Ignored redirects (stall, halt) do not count.
- IF_STATS_EN undefined: counter logic is omitted and the three counter outputs are tied to 0. All other behaviour is identical.

## Test plan
- Reset, then 4 free-running cycles with imem_data=addr-derived pattern -> PC sequence 0,4,8,12,16. IF/ID holds words at 0..12 with valid=1 and if_id_pc1=4..16.
- correct_b=1, npc_in=0x40 at PC=0x10 -> next PC=0x40, next IF/ID valid=0; the following cycle IF/ID holds the word at 0x40 with pc1=0x44; cnt_branch=1.
- stall=1 for 3 cycles with jmp=1, npc_in=0x80 -> PC and IF/ID unchanged, cnt_jmp=0. Drop stall with jmp=1 still held -> PC=0x80, cnt_jmp=1.
- halt_req=1 at PC=0x24 -> halted=1, PC stays 0x24 for 10 cycles, cnt_cycle frozen. go pulse -> halted=0, and the word at 0x24 reaches IF/ID two edges after go.
- halt_req and jmp in the same cycle -> HALT entered, PC unchanged, cnt_jmp unchanged.
- rst asserted in HALT with stall=1 -> PC=RESET_PC, valid=0, halted=0, counters 0. With IF_STATS_EN undefined, counters read 0 throughout the whole bench.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, RUN/HALT control.
// Define IF_STATS_EN to build the cycle/jump/branch performance counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             jmp,
  input  logic             correct_b,
  input  logic [31:0]      npc_in,
  input  logic             halt_req,
  input  logic             go,
  input  logic [31:0]      imem_data,
  output logic [31:0]      imem_addr,
  output logic [31:0]      if_id_ir,
  output logic [31:0]      if_id_pc1,
  output logic             if_id_valid,
  output logic             halted,
  output logic [CNT_W-1:0] cnt_cycle,
  output logic [CNT_W-1:0] cnt_jmp,
  output logic [CNT_W-1:0] cnt_branch
);

  typedef enum logic {StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc1_q, pc1_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic        redirect;

  assign pc_plus4 = pc_q + 32'd4;
  assign redirect = jmp | correct_b;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    unique case (state_q)
      StRun: begin
        if (halt_req) begin
          state_d = StHalt;
          ir_d    = 32'd0;
          pc1_d   = 32'd0;
          valid_d = 1'b0;
        end else if (stall) begin
          // Redirect is ignored here: ID operands are stale and get re-presented.
        end else if (redirect) begin
          pc_d    = npc_in;
          ir_d    = 32'd0;
          pc1_d   = 32'd0;
          valid_d = 1'b0;
        end else begin
          pc_d    = pc_plus4;
          ir_d    = imem_data;
          pc1_d   = pc_plus4;
          valid_d = 1'b1;
        end
      end
      StHalt: begin
        if (go) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
      pc1_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_ir    = ir_q;
  assign if_id_pc1   = pc1_q;
  assign if_id_valid = valid_q;
  assign halted      = (state_q == StHalt);

`ifdef IF_STATS_EN
  logic [CNT_W-1:0] cnt_cycle_q, cnt_cycle_d;
  logic [CNT_W-1:0] cnt_jmp_q, cnt_jmp_d;
  logic [CNT_W-1:0] cnt_branch_q, cnt_branch_d;
  logic             run_cycle, accept;

  assign run_cycle = (state_q == StRun);
  // A redirect is accepted only when neither halt nor stall overrides it.
  assign accept    = run_cycle & ~halt_req & ~stall & redirect;

  always_comb begin
    cnt_cycle_d  = cnt_cycle_q;
    cnt_jmp_d    = cnt_jmp_q;
    cnt_branch_d = cnt_branch_q;
    if (run_cycle)               cnt_cycle_d  = cnt_cycle_q + CNT_W'(1);
    if (accept && jmp)           cnt_jmp_d    = cnt_jmp_q + CNT_W'(1);
    if (accept && !jmp)          cnt_branch_d = cnt_branch_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_cycle_q  <= '0;
      cnt_jmp_q    <= '0;
      cnt_branch_q <= '0;
    end else begin
      cnt_cycle_q  <= cnt_cycle_d;
      cnt_jmp_q    <= cnt_jmp_d;
      cnt_branch_q <= cnt_branch_d;
    end
  end

  assign cnt_cycle  = cnt_cycle_q;
  assign cnt_jmp    = cnt_jmp_q;
  assign cnt_branch = cnt_branch_q;
`else
  assign cnt_cycle  = '0;
  assign cnt_jmp    = '0;
  assign cnt_branch = '0;
`endif

endmodule
